// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - run-control and retirement-trace monitor; optional feature macro: TRACE_FILTER_EN
module cpu_trace_monitor #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 16,
   parameter int LOOP_LIMIT = 4,
   parameter int MAX_CYCLES = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            retire_valid,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] alu_result,
   input  logic            reg_write,
   input  logic            mem_write,
   output logic            trace_valid,
   input  logic            trace_ready,
   output logic [XLEN-1:0] trace_pc,
   output logic [31:0]     trace_instr,
   output logic [XLEN-1:0] trace_alu,
   output logic [1:0]      trace_flags,
   output logic [31:0]     cycle_count,
   output logic [31:0]     instret_count,
   output logic [15:0]     drop_count,
   output logic            halted,
   output logic [1:0]      halt_cause
);

   localparam int          AW         = $clog2(DEPTH);
   localparam int          LW         = $clog2(LOOP_LIMIT + 1);
   localparam logic [31:0] EBREAK     = 32'h0010_0073;
   localparam logic [31:0] CYCLE_LAST = 32'(MAX_CYCLES - 1);
   localparam logic [AW:0] OCC_FULL   = (AW + 1)'(DEPTH);
   localparam logic [LW-1:0] LOOP_HIT = LW'(LOOP_LIMIT);

   localparam logic [1:0] CAUSE_EBREAK  = 2'b01;
   localparam logic [1:0] CAUSE_LOOP    = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

   typedef enum logic {
      S_RUN,
      S_HALT
   } state_t;

   state_t state;

   // FIFO storage, one array per record field
   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [31:0]     mem_instr [DEPTH];
   logic [XLEN-1:0] mem_alu   [DEPTH];
   logic [1:0]      mem_flags [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   occ;

   logic [XLEN-1:0] prev_pc;
   logic [LW-1:0]   loop_cnt;

   logic          in_run;
   logic          retire;
   logic          push_req;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          push_drop;
   logic [LW-1:0] loop_next;
   logic          hit_ebreak;
   logic          hit_loop;
   logic          hit_timeout;

   assign in_run = (state == S_RUN);
   assign retire = in_run && retire_valid;

`ifdef TRACE_FILTER_EN
   // only architecturally visible retirements are recorded
   assign push_req = retire && (reg_write || mem_write);
`else
   assign push_req = retire;
`endif

   assign full      = (occ == OCC_FULL);
   assign pop       = trace_valid && trace_ready;
   assign push_ok   = push_req && (!full || pop);
   assign push_drop = push_req && full && !pop;

   // a repeated PC extends the current run, any other PC starts a new run of one
   assign loop_next   = (pc == prev_pc) ? (loop_cnt + LW'(1)) : LW'(1);
   assign hit_ebreak  = retire && (instr == EBREAK);
   assign hit_loop    = retire && (loop_next == LOOP_HIT);
   assign hit_timeout = in_run && (cycle_count == CYCLE_LAST);

   // run/halt state machine with registered halt status, EBREAK > self-loop > timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         halted     <= 1'b0;
         halt_cause <= 2'b00;
      end else begin
         case (state)
            S_RUN: begin
               if (hit_ebreak) begin
                  state      <= S_HALT;
                  halted     <= 1'b1;
                  halt_cause <= CAUSE_EBREAK;
               end else if (hit_loop) begin
                  state      <= S_HALT;
                  halted     <= 1'b1;
                  halt_cause <= CAUSE_LOOP;
               end else if (hit_timeout) begin
                  state      <= S_HALT;
                  halted     <= 1'b1;
                  halt_cause <= CAUSE_TIMEOUT;
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

   // saturating cycle and retirement counters, frozen outside RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count   <= 32'd0;
         instret_count <= 32'd0;
      end else if (in_run) begin
         if (cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
         end
         if (retire_valid && (instret_count != 32'hFFFF_FFFF)) begin
            instret_count <= instret_count + 32'd1;
         end
      end
   end

   // self-loop tracking: previous retired PC and length of the current same-PC run
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_pc  <= '0;
         loop_cnt <= '0;
      end else if (retire) begin
         prev_pc  <= pc;
         loop_cnt <= loop_next;
      end
   end

   // saturating count of records lost to a full FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_count <= 16'd0;
      end else if (push_drop && (drop_count != 16'hFFFF)) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_ok && !pop) begin
            occ <= occ + (AW + 1)'(1);
         end else if (pop && !push_ok) begin
            occ <= occ - (AW + 1)'(1);
         end
      end
   end

   // FIFO storage write; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_pc[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= instr;
         mem_alu[wr_ptr]   <= alu_result;
         mem_flags[wr_ptr] <= {mem_write, reg_write};
      end
   end

   assign trace_valid = (occ != '0);
   assign trace_pc    = mem_pc[rd_ptr];
   assign trace_instr = mem_instr[rd_ptr];
   assign trace_alu   = mem_alu[rd_ptr];
   assign trace_flags = mem_flags[rd_ptr];

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - scoreboard bench for cpu_trace_monitor
module tb_cpu_trace_monitor;

   localparam int XLEN       = 32;
   localparam int DEPTH      = 16;
   localparam int LOOP_LIMIT = 4;
   localparam int MAX_CYCLES = 50;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic            clk = 1'b0;
   logic            rst;
   logic            retire_valid;
   logic [XLEN-1:0] pc;
   logic [31:0]     instr;
   logic [XLEN-1:0] alu_result;
   logic            reg_write;
   logic            mem_write;
   logic            trace_valid;
   logic            trace_ready;
   logic [XLEN-1:0] trace_pc;
   logic [31:0]     trace_instr;
   logic [XLEN-1:0] trace_alu;
   logic [1:0]      trace_flags;
   logic [31:0]     cycle_count;
   logic [31:0]     instret_count;
   logic [15:0]     drop_count;
   logic            halted;
   logic [1:0]      halt_cause;

   cpu_trace_monitor #(
      .XLEN(XLEN), .DEPTH(DEPTH), .LOOP_LIMIT(LOOP_LIMIT), .MAX_CYCLES(MAX_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .retire_valid(retire_valid), .pc(pc), .instr(instr),
      .alu_result(alu_result), .reg_write(reg_write), .mem_write(mem_write),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
      .trace_instr(trace_instr), .trace_alu(trace_alu), .trace_flags(trace_flags),
      .cycle_count(cycle_count), .instret_count(instret_count), .drop_count(drop_count),
      .halted(halted), .halt_cause(halt_cause)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
      logic [1:0]  flags;
   } rec_t;

   rec_t exp_q[$];

   int checks = 0;
   int errors = 0;

   // reference state: what the monitor should show after the most recent edge
   int          m_cycle, m_instret, m_drop, m_occ, m_loop, m_cause;
   logic [31:0] m_prev;
   bit          m_halted;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cycle = 0; m_instret = 0; m_drop = 0; m_occ = 0; m_loop = 0; m_cause = 0;
      m_prev = 0; m_halted = 0;
      exp_q.delete();
   endtask

   // one clock edge of the monitor's rules, applied to the inputs about to be sampled
   task automatic model_step(input bit rv, input logic [31:0] p, input logic [31:0] i,
                             input logic [31:0] a, input bit rw, input bit mw, input bit rdy);
      bit pop, push, ebk, lp, to;
      rec_t r;
      pop = (m_occ > 0) && rdy;
      push = 0;
      if (!m_halted) begin
         to = (m_cycle == MAX_CYCLES - 1);
         m_cycle++;
         ebk = 0;
         lp = 0;
         if (rv) begin
            m_instret++;
            m_loop = (p == m_prev) ? m_loop + 1 : 1;
            m_prev = p;
            ebk = (i == EBREAK);
            lp = (m_loop == LOOP_LIMIT);
`ifdef TRACE_FILTER_EN
            push = rw || mw;
`else
            push = 1;
`endif
         end
         if (ebk) begin
            m_halted = 1; m_cause = 1;
         end else if (lp) begin
            m_halted = 1; m_cause = 2;
         end else if (to) begin
            m_halted = 1; m_cause = 3;
         end
      end
      if (push) begin
         if (m_occ < DEPTH || pop) begin
            r.pc = p; r.instr = i; r.alu = a; r.flags = {mw, rw};
            exp_q.push_back(r);
            m_occ++;
         end else if (m_drop < 65535) begin
            m_drop++;
         end
      end
      if (pop) m_occ--;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_cycle"}, cycle_count, 32'(m_cycle));
      chk({tag, "_instret"}, instret_count, 32'(m_instret));
      chk({tag, "_drop"}, {16'd0, drop_count}, 32'(m_drop));
      chk({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
      chk({tag, "_cause"}, {30'd0, halt_cause}, 32'(m_cause));
      chk({tag, "_valid"}, {31'd0, trace_valid}, {31'd0, (m_occ != 0)});
   endtask

   task automatic cyc(input bit rv, input logic [31:0] p, input logic [31:0] i,
                      input bit rw, input bit mw, input bit rdy);
      logic [31:0] a;
      a = $urandom;
      retire_valid = rv; pc = p; instr = i; alu_result = a;
      reg_write = rw; mem_write = mw; trace_ready = rdy;
      model_step(rv, p, i, a, rw, mw, rdy);
      @(posedge clk);
      #1;
      check_state("cyc");
   endtask

   task automatic do_reset();
      rst = 1'b1; retire_valid = 1'b0; trace_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check_state("reset");
   endtask

   task automatic drain();
      for (int k = 0; k < DEPTH + 2; k++) cyc(0, 32'h0, NOP, 0, 0, 1);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // monitor: pops the scoreboard whenever the DUT hands over a record
   always @(negedge clk) begin
      if (!rst && trace_valid && trace_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_record", {31'd0, trace_valid}, 32'd0);
         end else begin
            rec_t e;
            e = exp_q.pop_front();
            chk("rec_pc", trace_pc, e.pc);
            chk("rec_instr", trace_instr, e.instr);
            chk("rec_alu", trace_alu, e.alu);
            chk("rec_flags", {30'd0, trace_flags}, {30'd0, e.flags});
         end
      end
   end

   initial begin
      logic [31:0] rp, ri;
      rst = 1'b1; retire_valid = 0; pc = 0; instr = 0; alu_result = 0;
      reg_write = 0; mem_write = 0; trace_ready = 0;
      model_reset();

      // in-order trace, then EBREAK halt with frozen counters
      do_reset();
      chk("reset_valid", {31'd0, trace_valid}, 32'd0);
      chk("reset_cause", {30'd0, halt_cause}, 32'd0);
      cyc(1, 32'h0, NOP, 1, 0, 1);
      cyc(1, 32'h4, NOP, 1, 0, 1);
      cyc(1, 32'h8, NOP, 0, 1, 1);
      chk("three_instret", instret_count, 32'd3);
      chk("three_cycles", cycle_count, 32'd3);
      cyc(1, 32'h10, EBREAK, 0, 0, 0);
      chk("ebreak_halted", {31'd0, halted}, 32'd1);
      chk("ebreak_cause", {30'd0, halt_cause}, 32'd1);
      for (int k = 0; k < 10; k++) cyc(1, 32'(k * 4 + 64), NOP, 1, 1, 1);
      chk("ebreak_frozen_instret", instret_count, 32'd4);
      drain();

      // self-loop at a fixed PC
      do_reset();
      for (int k = 0; k < 4; k++) cyc(1, 32'h20, NOP, 1, 0, 1);
      chk("loop_cause", {30'd0, halt_cause}, 32'd2);
      chk("loop_instret", instret_count, 32'd4);
      drain();

      // fill with consumer stalled, then push while full and popping
      do_reset();
      for (int k = 0; k < 20; k++) cyc(1, 32'(k * 4 + 32'h100), NOP, 1, 0, 0);
      chk("fill_drops", {16'd0, drop_count}, 32'd4);
      for (int k = 0; k < 10; k++) cyc(1, 32'(k * 4 + 32'h200), NOP, 1, 1, 1);
      chk("full_pushpop_drops", {16'd0, drop_count}, 32'd4);
      drain();

      // timeout, then reset from HALT
      do_reset();
      for (int k = 0; k < MAX_CYCLES + 3; k++) cyc(0, 32'h0, NOP, 0, 0, 1);
      chk("timeout_cause", {30'd0, halt_cause}, 32'd3);
      chk("timeout_cycles", cycle_count, 32'(MAX_CYCLES));
      do_reset();
      chk("rst_halt_halted", {31'd0, halted}, 32'd0);

`ifdef TRACE_FILTER_EN
      // alternating unflagged retirements are counted but not traced
      do_reset();
      for (int k = 0; k < 8; k++) cyc(1, 32'(k * 4), NOP, k[0], 0, 1);
      chk("filter_instret", instret_count, 32'd8);
      drain();
`endif

      // randomized runs
      for (int run = 0; run < 8; run++) begin
         do_reset();
         rp = 0;
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 99) >= 35) rp = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            ri = ($urandom_range(0, 99) < 3) ? EBREAK : $urandom;
            cyc($urandom_range(0, 99) < 80, rp, ri, 1'($urandom), 1'($urandom),
                $urandom_range(0, 99) < 50);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
